i2s_frame_reader: RTL
=====================

Name: i2s_frame_reader

Overview:
- Consumer stage after the I2S MSB receiver's bit-wide circular frame RAM.
- On request, reads the most recently completed 256-bit frame over the RAM read port and deserializes it into 8 channel samples (MSB first, 32-bit slots).
- Presents the samples on a valid/ready stream to the downstream packer (USB/ADAT side).

Parameters:
- CIRC_BUF_BITS, 3: log2 of the number of frames in the RAM; must match the receiver.
- SAMPLE_BITS, 24: leading bits taken from each 32-bit slot; range 1..32.
- RAM_READ_LATENCY, 1: cycles from ram_read_en_o/address to valid ram_read_data_i; range 1..3.

Ports:
- clk_i  in  1  system clock; same domain as the receiver's RAM write side.
- rst_i  in  1  synchronous, active-high reset.
- last_good_frame_idx_i  in  CIRC_BUF_BITS  index of the newest complete frame, from the receiver.
- frame_req_i  in  1  one-cycle pulse requesting the read of one frame.
- frame_busy_o  out  1  high from acceptance of a request until the last sample handshakes.
- ram_read_addr_o  out  CIRC_BUF_BITS+8  {frame, slot[2:0], bit[4:0]}.
- ram_read_en_o  out  1  RAM read strobe.
- ram_read_data_i  in  1  RAM read data.
- sample_data_o  out  SAMPLE_BITS  assembled sample; first bit read is the MSB.
- sample_chan_o  out  3  slot index 0..7.
- sample_last_o  out  1  high with channel 7.
- sample_valid_o  out  1  stream valid.
- sample_ready_i  in  1  stream ready.
- frame_overrun_o  out  1  sticky: a request arrived while busy.
- frame_repeat_o  out  1  optional-feature flag; see Optional Feature.

Behaviour:
- Reset values: sample_valid_o, ram_read_en_o, frame_busy_o, frame_overrun_o and frame_repeat_o are 0. sample_data_o, sample_chan_o and ram_read_addr_o are 0. FSM is in IDLE.
- FSM states: IDLE, READ, WAIT, PRESENT.
- IDLE:
  - frame_req_i at cycle T latches last_good_frame_idx_i into frame_r and clears slot_r.
  - Moves to READ at T+1; frame_busy_o is 1 from T+1.
- READ:
  - Issues SAMPLE_BITS consecutive reads with ram_read_en_o=1 and address {frame_r, slot_r, bit_r}, bit_r counting 0..SAMPLE_BITS-1.
  - Slot bits SAMPLE_BITS..31 are never read.
  - After the last read, goes to WAIT.
- Data capture: a RAM_READ_LATENCY-deep valid pipeline tags returning bits. Each tagged bit is shifted in LSB-side (shift left), so the first bit read ends up as the MSB.
- WAIT:
  - Lasts RAM_READ_LATENCY cycles; ram_read_en_o=0.
  - The final bit is captured on the last WAIT edge, then the FSM moves to PRESENT.
- PRESENT:
  - sample_valid_o=1; data, chan and last are held stable until sample_ready_i=1.
  - On handshake: if slot_r=7, go to IDLE and drop frame_busy_o in the same edge. Otherwise increment slot_r and go to READ.
  - No read of the next slot overlaps PRESENT.
- Latency with SAMPLE_BITS=24 and RAM_READ_LATENCY=1: request at T gives reads at T+1..T+24 and channel-0 valid at T+26.
- Stream rules:
  - Valid never drops without a handshake.
  - Ready may be high before valid.
  - Exactly one beat per slot.
- Request while busy, including the cycle the final handshake occurs:
  - The request is ignored and frame_overrun_o is set sticky.
  - frame_overrun_o clears only on rst_i.
- The frame index is latched once per request. Changes on last_good_frame_idx_i mid-frame have no effect.
- Address arithmetic: slot and bit fields never carry into the frame field. Frame index wraps modulo 2^CIRC_BUF_BITS as supplied.
- rst_i mid-frame, in any state: the next cycle is IDLE with all outputs at reset values; the partial frame is discarded and no beat is emitted.

Optional Feature:
- Macro: I2S_FRAME_READER_REPEAT_DETECT_EN.
- Enabled:
  - Keep prev_frame_r and a prev_valid_r flag (0 at reset).
  - On request acceptance, if prev_valid_r is set and the latched index equals prev_frame_r, frame_repeat_o is 1 for that whole frame (until busy drops). Otherwise it is 0.
  - prev_frame_r updates at each accepted request.
- Disabled: frame_repeat_o is tied 0 and no extra registers are built.

Decomposition:
- Package i2s_pkg holds:
  - FRAME_BITS=256, SLOT_BITS=32, NUM_SLOTS=8, SLOT_IDX_W=3, BIT_IDX_W=5.
  - Typedef for the reader FSM state enum.
  - Typedef ram_addr_t built from CIRC_BUF_BITS.
- One sub-module is natural: bit_delay_line (parameterized depth; carries read-valid through RAM_READ_LATENCY stages). Everything else stays inline.

Test Plan:
- Preload frame 5 so slot n holds 32'hA5_C3_00_00 ^ (n<<24); pulse frame_req_i with idx=5 -> channels 0..7 emitted in order, sample_data_o = upper 24 bits of each pattern, sample_last_o only on channel 7, channel-0 valid at T+26.
- Hold sample_ready_i low for 10 cycles on channel 3 -> data, chan and valid stable throughout; no ram_read_en_o pulses in that window; sample count stays 8.
- Pulse frame_req_i mid-frame -> frame_overrun_o=1 and stays 1; the current frame completes normally; no second frame starts.
- idx=7 with CIRC_BUF_BITS=3 -> addresses 0x7_00..0x7_F7 read, never 0x8xx; RAM_READ_LATENCY=3 build -> identical samples, channel-0 valid at T+28.
- Assert rst_i during slot 4 READ -> next cycle all outputs are 0 and FSM is IDLE; a new request afterwards yields a full, correct 8-beat frame.
- With I2S_FRAME_READER_REPEAT_DETECT_EN: requests with idx 2, 2, 3 -> frame_repeat_o = 0, 1, 0 per frame; without the macro it is always 0.

Source files
------------

// File: rtl/i2s_pkg.sv
// ============================================================================
//  Package     : i2s_pkg
//  Description : Shared frame geometry, reader FSM state type and RAM address
//                type for the I2S frame reader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2s_pkg;

   localparam int FRAME_BITS        = 256;
   localparam int SLOT_BITS         = 32;
   localparam int NUM_SLOTS         = 8;
   localparam int SLOT_IDX_W        = 3;
   localparam int BIT_IDX_W         = 5;

   // Default circular-buffer depth (log2 frames) shared with the receiver.
   localparam int DEF_CIRC_BUF_BITS = 3;

   // RAM bit address: {frame, slot, bit}.
   typedef logic [DEF_CIRC_BUF_BITS+SLOT_IDX_W+BIT_IDX_W-1:0] ram_addr_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_READ    = 2'd1,
      ST_WAIT    = 2'd2,
      ST_PRESENT = 2'd3
   } reader_state_t;

   // True when the slot index refers to the final slot of a frame.
   function automatic logic slot_is_last(input logic [SLOT_IDX_W-1:0] slot);
      return slot == SLOT_IDX_W'(NUM_SLOTS - 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/i2s_frame_reader_bit_delay_line.sv
// ============================================================================
//  Module      : bit_delay_line
//  Description : DEPTH-stage shift register for a single bit; used to tag RAM
//                read data as valid RAM_READ_LATENCY cycles after the strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_delay_line #(
   parameter int DEPTH = 1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic din_i,
   output logic dout_o
);

   logic [DEPTH-1:0] stage_r;

   generate
      if (DEPTH == 1) begin : g_single
         // Single register stage.
         always_ff @(posedge clk_i) begin
            if (rst_i) stage_r <= 1'b0;
            else       stage_r <= din_i;
         end
      end else begin : g_multi
         // Shift the bit one stage per cycle toward the output.
         always_ff @(posedge clk_i) begin
            if (rst_i) stage_r <= '0;
            else       stage_r <= {stage_r[DEPTH-2:0], din_i};
         end
      end
   endgenerate

   assign dout_o = stage_r[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/i2s_frame_reader.sv
// ============================================================================
//  Module      : i2s_frame_reader
//  Description : Reads the newest complete 256-bit frame from the receiver's
//                bit-wide circular RAM and emits 8 MSB-first channel samples
//                on a valid/ready stream.
//  Options     : I2S_FRAME_READER_REPEAT_DETECT_EN - flag frames whose index
//                equals the previously accepted one on frame_repeat_o.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_frame_reader
   import i2s_pkg::*;
#(
   parameter int CIRC_BUF_BITS    = 3,
   parameter int SAMPLE_BITS      = 24,
   parameter int RAM_READ_LATENCY = 1
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [CIRC_BUF_BITS-1:0]              last_good_frame_idx_i,
   input  logic                                  frame_req_i,
   output logic                                  frame_busy_o,
   output logic [CIRC_BUF_BITS+SLOT_IDX_W+BIT_IDX_W-1:0] ram_read_addr_o,
   output logic                                  ram_read_en_o,
   input  logic                                  ram_read_data_i,
   output logic [SAMPLE_BITS-1:0]                sample_data_o,
   output logic [SLOT_IDX_W-1:0]                 sample_chan_o,
   output logic                                  sample_last_o,
   output logic                                  sample_valid_o,
   input  logic                                  sample_ready_i,
   output logic                                  frame_overrun_o,
   output logic                                  frame_repeat_o
);

   localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(SAMPLE_BITS - 1);
   localparam logic [1:0]           LAST_WAIT = 2'(RAM_READ_LATENCY - 1);

   reader_state_t              state_r;
   reader_state_t              state_nx;
   logic                       accept;
   logic                       handshake;

   logic [CIRC_BUF_BITS-1:0]   frame_r;
   logic [SLOT_IDX_W-1:0]      slot_r;
   logic [BIT_IDX_W-1:0]       bit_r;
   logic [1:0]                 wait_cnt_r;
   logic [SAMPLE_BITS-1:0]     sample_r;
   logic                       overrun_r;
   logic                       rd_tag;
   logic                       busy;

   assign busy = (state_r != ST_IDLE);

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_r <= ST_IDLE;
      else       state_r <= state_nx;
   end

   // Next-state decode plus request-accept and stream-handshake strobes.
   always_comb begin
      state_nx  = state_r;
      accept    = 1'b0;
      handshake = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (frame_req_i) begin
               accept   = 1'b1;
               state_nx = ST_READ;
            end
         end
         ST_READ: begin
            if (bit_r == LAST_BIT) state_nx = ST_WAIT;
         end
         ST_WAIT: begin
            if (wait_cnt_r == LAST_WAIT) state_nx = ST_PRESENT;
         end
         ST_PRESENT: begin
            if (sample_ready_i) begin
               handshake = 1'b1;
               state_nx  = slot_is_last(slot_r) ? ST_IDLE : ST_READ;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Tags returning RAM bits so capture lines up with the read latency.
   bit_delay_line #(
      .DEPTH (RAM_READ_LATENCY)
   ) u_rd_valid (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .din_i  (ram_read_en_o),
      .dout_o (rd_tag)
   );

   // Frame/slot/bit counters, sample shift register and sticky overrun flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         frame_r    <= '0;
         slot_r     <= '0;
         bit_r      <= '0;
         wait_cnt_r <= '0;
         sample_r   <= '0;
         overrun_r  <= 1'b0;
      end else begin
         if (accept) begin
            frame_r <= last_good_frame_idx_i;
            slot_r  <= '0;
         end

         if (state_r == ST_READ) begin
            bit_r <= (bit_r == LAST_BIT) ? '0 : bit_r + BIT_IDX_W'(1);
         end

         if (state_r == ST_WAIT && wait_cnt_r != LAST_WAIT) begin
            wait_cnt_r <= wait_cnt_r + 2'd1;
         end else begin
            wait_cnt_r <= '0;
         end

         // Shifting left places the first bit read at the MSB.
         if (rd_tag) begin
            sample_r <= SAMPLE_BITS'({sample_r, ram_read_data_i});
         end

         if (handshake && !slot_is_last(slot_r)) begin
            slot_r <= slot_r + SLOT_IDX_W'(1);
         end

         if (frame_req_i && busy) begin
            overrun_r <= 1'b1;
         end
      end
   end

`ifdef I2S_FRAME_READER_REPEAT_DETECT_EN
   logic [CIRC_BUF_BITS-1:0] prev_frame_r;
   logic                     prev_valid_r;
   logic                     repeat_r;

   // Compare each accepted index with the previously accepted one.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev_frame_r <= '0;
         prev_valid_r <= 1'b0;
         repeat_r     <= 1'b0;
      end else if (accept) begin
         repeat_r     <= prev_valid_r && (last_good_frame_idx_i == prev_frame_r);
         prev_frame_r <= last_good_frame_idx_i;
         prev_valid_r <= 1'b1;
      end
   end

   assign frame_repeat_o = repeat_r & busy;
`else
   assign frame_repeat_o = 1'b0;
`endif

   assign frame_busy_o    = busy;
   assign ram_read_en_o   = (state_r == ST_READ);
   assign ram_read_addr_o = ram_read_en_o ? {frame_r, slot_r, bit_r} : '0;
   assign sample_valid_o  = (state_r == ST_PRESENT);
   assign sample_data_o   = sample_r;
   assign sample_chan_o   = slot_r;
   assign sample_last_o   = sample_valid_o && slot_is_last(slot_r);
   assign frame_overrun_o = overrun_r;

endmodule

`default_nettype wire
